// File: rtl/wb_board_io.sv
`default_nettype none
// ============================================================================
// Module   : wb_board_io
// Purpose  : Board I/O peripheral on the wishbone bus. Switches and buttons
//            are synchronised and debounced; per-bit edge interrupts with
//            mask, edge mode and a sticky write-1-to-clear pending register.
//            Drives LEDs and a multiplexed N-digit 7-segment display with
//            per-digit enable and dot.
// Ports    : clk            - clock (also the wishbone clock)
//            rst            - asynchronous active-low reset
//            switch, btn    - raw input levels (btn: 1 = pressed)
//            led            - LED drive, 1 = lit
//            segment        - active-low {dot, g..a}
//            anode          - active-low digit select
//            wbs_*          - wishbone slave (word-addressed registers)
//            interrupt      - active-high level interrupt
// Revision : 1.0 - initial release
// ============================================================================
module wb_board_io #(
    parameter int DEV_ADDR_BITS = 8,
    parameter int N_SW          = 8,
    parameter int N_BTN         = 5,
    parameter int N_LED         = 8,
    parameter int N_DIGIT       = 4,
    parameter int DEB_CYCLES    = 250000,
    parameter int SCAN_CYCLES   = 50000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_SW-1:0]            switch,
    input  logic [N_BTN-1:0]           btn,
    output logic [N_LED-1:0]           led,
    output logic [7:0]                 segment,
    output logic [N_DIGIT-1:0]         anode,
    input  logic                       wbs_cs_i,
    input  logic [DEV_ADDR_BITS-1:2]   wbs_addr_i,
    input  logic [3:0]                 wbs_sel_i,
    input  logic [31:0]                wbs_data_i,
    input  logic                       wbs_we_i,
    output logic [31:0]                wbs_data_o,
    output logic                       wbs_ack_o,
    output logic                       interrupt
);

    localparam int NI  = N_SW + N_BTN;
    localparam int DBW = $clog2(DEB_CYCLES);
    localparam int SCW = $clog2(SCAN_CYCLES);
    localparam int DW  = (N_DIGIT > 1) ? $clog2(N_DIGIT) : 1;
    localparam int AW  = DEV_ADDR_BITS - 2;

    localparam logic [AW-1:0] A_IN   = AW'(0);
    localparam logic [AW-1:0] A_LED  = AW'(1);
    localparam logic [AW-1:0] A_SEGD = AW'(2);
    localparam logic [AW-1:0] A_SEGC = AW'(3);
    localparam logic [AW-1:0] A_MASK = AW'(4);
    localparam logic [AW-1:0] A_PEND = AW'(5);
    localparam logic [AW-1:0] A_EDGE = AW'(6);

    // ------------------------------------------------------------------
    // Input synchronisation and debounce
    // ------------------------------------------------------------------
    logic [NI-1:0]  in_raw, sync1, sync2, sample, deb, deb_prev, stable;
    logic [DBW-1:0] deb_cnt;
    logic           deb_tick;

    assign in_raw   = {btn, switch};
    assign deb_tick = (deb_cnt == DBW'(DEB_CYCLES - 1));
    // A bit is accepted only when two consecutive ticks saw the same level.
    assign stable   = ~(sync2 ^ sample);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '0;
            sync2    <= '0;
            sample   <= '0;
            deb      <= '0;
            deb_prev <= '0;
            deb_cnt  <= '0;
        end else begin
            sync1    <= in_raw;
            sync2    <= sync1;
            deb_prev <= deb;
            deb_cnt  <= deb_tick ? '0 : deb_cnt + 1'b1;
            if (deb_tick) begin
                sample <= sync2;
                deb    <= (deb & ~stable) | (sync2 & stable);
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file and bus
    // ------------------------------------------------------------------
    logic [4*N_DIGIT-1:0] seg_data;
    logic [N_DIGIT-1:0]   seg_en, seg_dot;
    logic [NI-1:0]        irq_mask, irq_pend, irq_edge, evt, w1c;
    logic [31:0]          bm, rd_value, wr_value;
    logic                 access, wr;

    assign access = wbs_cs_i & ~wbs_ack_o;
    assign wr     = access & wbs_we_i;
    assign bm     = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                     {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

    // Rising edges always count; falling edges only in edge mode.
    assign evt = (deb & ~deb_prev) | (~deb & deb_prev & irq_edge);
    assign w1c = (wr && (wbs_addr_i == A_PEND)) ? (wbs_data_i[NI-1:0] & bm[NI-1:0]) : '0;

    always_comb begin
        rd_value = '0;
        case (wbs_addr_i)
            A_IN:    rd_value = 32'(deb);
            A_LED:   rd_value = 32'(led);
            A_SEGD:  rd_value = 32'(seg_data);
            A_SEGC:  rd_value = (32'(seg_dot) << 8) | 32'(seg_en);
            A_MASK:  rd_value = 32'(irq_mask);
            A_PEND:  rd_value = 32'(irq_pend);
            A_EDGE:  rd_value = 32'(irq_edge);
            default: rd_value = '0;
        endcase
    end

    // Byte-merged write value for the addressed RW register.
    assign wr_value = (rd_value & ~bm) | (wbs_data_i & bm);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbs_ack_o  <= 1'b0;
            wbs_data_o <= '0;
            led        <= '0;
            seg_data   <= '0;
            seg_en     <= '0;
            seg_dot    <= '0;
            irq_mask   <= '0;
            irq_pend   <= '0;
            irq_edge   <= '0;
            interrupt  <= 1'b0;
        end else begin
            wbs_ack_o  <= access;
            wbs_data_o <= access ? rd_value : '0;
            if (wr) begin
                case (wbs_addr_i)
                    A_LED:  led      <= wr_value[N_LED-1:0];
                    A_SEGD: seg_data <= wr_value[4*N_DIGIT-1:0];
                    A_SEGC: begin
                        seg_en  <= wr_value[N_DIGIT-1:0];
                        seg_dot <= wr_value[8 +: N_DIGIT];
                    end
                    A_MASK: irq_mask <= wr_value[NI-1:0];
                    A_EDGE: irq_edge <= wr_value[NI-1:0];
                    default: ;
                endcase
            end
            // A new event in the clearing cycle keeps the bit set.
            irq_pend  <= (irq_pend & ~w1c) | evt;
            interrupt <= |(irq_pend & irq_mask);
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, wr_value, wbs_data_i};

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [SCW-1:0]     scan_cnt;
    logic [DW-1:0]      digit;
    logic [N_DIGIT-1:0] digit_sel;
    logic [3:0]         cur_hex;
    logic               cur_en, cur_dot;

    function automatic logic [6:0] hex7seg(input logic [3:0] h);
        case (h)
            4'h0: hex7seg = 7'h3F;  4'h1: hex7seg = 7'h06;
            4'h2: hex7seg = 7'h5B;  4'h3: hex7seg = 7'h4F;
            4'h4: hex7seg = 7'h66;  4'h5: hex7seg = 7'h6D;
            4'h6: hex7seg = 7'h7D;  4'h7: hex7seg = 7'h07;
            4'h8: hex7seg = 7'h7F;  4'h9: hex7seg = 7'h6F;
            4'hA: hex7seg = 7'h77;  4'hB: hex7seg = 7'h7C;
            4'hC: hex7seg = 7'h39;  4'hD: hex7seg = 7'h5E;
            4'hE: hex7seg = 7'h79;  4'hF: hex7seg = 7'h71;
            default: hex7seg = 7'h00;
        endcase
    endfunction

    always_comb begin
        digit_sel = '0;
        cur_en    = 1'b0;
        cur_dot   = 1'b0;
        cur_hex   = 4'h0;
        for (int k = 0; k < N_DIGIT; k++) begin
            if (digit == DW'(k)) begin
                digit_sel[k] = 1'b1;
                cur_en       = seg_en[k];
                cur_dot      = seg_dot[k];
                cur_hex      = seg_data[4*k +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            digit    <= '0;
            anode    <= '1;
            segment  <= 8'hFF;
        end else begin
            if (scan_cnt == SCW'(SCAN_CYCLES - 1)) begin
                scan_cnt <= '0;
                digit    <= (digit == DW'(N_DIGIT - 1)) ? '0 : digit + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            anode   <= cur_en ? ~digit_sel : '1;
            segment <= cur_en ? ~{cur_dot, hex7seg(cur_hex)} : 8'hFF;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_board_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_board_io
// Purpose  : Self-checking bench for wb_board_io. Bus accesses push their
//            expected read data into a scoreboard queue; a monitor pops and
//            compares on every ack. Expectations come from a register-level
//            model with inputs treated as settled levels.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_board_io;

    localparam int NI = 13;
    localparam logic [31:0] NIM = 32'h1FFF;

    logic        clk, rst;
    logic [7:0]  sw;
    logic [4:0]  btn;
    logic [7:0]  led;
    logic [7:0]  segment;
    logic [3:0]  anode;
    logic        cs, we, ack, irq;
    logic [7:2]  addr;
    logic [3:0]  sel;
    logic [31:0] wdata, rdata;

    wb_board_io #(
        .DEV_ADDR_BITS(8), .N_SW(8), .N_BTN(5), .N_LED(8), .N_DIGIT(4),
        .DEB_CYCLES(4), .SCAN_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .switch(sw), .btn(btn), .led(led),
        .segment(segment), .anode(anode), .wbs_cs_i(cs), .wbs_addr_i(addr),
        .wbs_sel_i(sel), .wbs_data_i(wdata), .wbs_we_i(we),
        .wbs_data_o(rdata), .wbs_ack_o(ack), .interrupt(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_in, m_led, m_segd, m_en, m_dot, m_mask, m_pend, m_edge;
    logic [6:0]  font [16];

    function automatic logic [31:0] m_read(int idx);
        case (idx)
            0: return m_in;
            1: return m_led;
            2: return m_segd;
            3: return (m_dot << 8) | m_en;
            4: return m_mask;
            5: return m_pend;
            6: return m_edge;
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_write(int idx, logic [3:0] s, logic [31:0] d);
        logic [31:0] bmask, mg;
        bmask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        mg = (m_read(idx) & ~bmask) | (d & bmask);
        case (idx)
            1: m_led  = mg & 32'hFF;
            2: m_segd = mg & 32'hFFFF;
            3: begin m_en = mg & 32'hF; m_dot = (mg >> 8) & 32'hF; end
            4: m_mask = mg & NIM;
            5: m_pend = m_pend & ~(d & bmask & NIM);
            6: m_edge = mg & NIM;
            default: ;
        endcase
    endfunction

    function automatic void m_reset();
        m_in = 0; m_led = 0; m_segd = 0; m_en = 0; m_dot = 0;
        m_mask = 0; m_pend = 0; m_edge = 0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard + monitor ----------------
    typedef struct { logic [31:0] exp; bit chk; int idx; } sb_t;
    sb_t sb[$];
    bit  prev_ack = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (ack) begin
                if (prev_ack) begin
                    checks++; errors++;
                    $display("FAIL ack_width: ack high two cycles in a row");
                end
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: data %h", rdata);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    if (e.chk) begin
                        checks++;
                        if (rdata !== e.exp) begin
                            errors++;
                            $display("FAIL read_idx%0d: got %h expected %h", e.idx, rdata, e.exp);
                        end
                    end
                end
            end else if (rdata !== 32'h0) begin
                checks++; errors++;
                $display("FAIL data_idle: got %h expected 00000000", rdata);
            end
            prev_ack = ack;
        end else begin
            prev_ack = 0;
        end
    end

    // Called right after a negedge; returns after the negedge following ack.
    task automatic bus(input bit wr, input int idx, input logic [3:0] s,
                       input logic [31:0] d, input bit chk, output logic [31:0] rd);
        bit got;
        sb_t e;
        e.exp = m_read(idx); e.chk = chk; e.idx = idx;
        sb.push_back(e);
        cs = 1'b1; we = wr; addr = 6'(idx); sel = s; wdata = d;
        got = 0;
        rd  = 32'h0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1; rd = rdata; end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL ack_timeout: idx %0d no ack within 4 cycles", idx);
        end
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
        if (wr) m_write(idx, s, d);
    endtask

    task automatic bw(int idx, logic [31:0] d);
        logic [31:0] r;
        bus(1'b1, idx, 4'hF, d, 1'b1, r);
    endtask

    task automatic br(int idx);
        logic [31:0] r;
        bus(1'b0, idx, 4'hF, 32'h0, 1'b1, r);
    endtask

    task automatic drive_in(logic [31:0] v);
        sw  = v[7:0];
        btn = v[12:8];
    endtask

    // Apply a stable input level and let it debounce fully.
    task automatic set_inputs(logic [31:0] v);
        logic [31:0] rise, fall;
        v = v & NIM;
        drive_in(v);
        repeat (20) @(negedge clk);
        rise = v & ~m_in;
        fall = ~v & m_in;
        m_pend = m_pend | rise | (fall & m_edge);
        m_in = v;
    endtask

    task automatic check_outputs();
        @(negedge clk);
        check("interrupt", {31'h0, irq}, {31'h0, |(m_pend & m_mask)});
        check("led", {24'h0, led}, m_led & 32'hFF);
    endtask

    task automatic wait_to(int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_display();
        int prev_d, run, dis;
        bit first;
        bit seen [4];
        prev_d = -1; run = 0; first = 1; dis = -1;
        for (int k = 0; k < 4; k++) begin
            seen[k] = 0;
            if (!m_en[k] && dis < 0) dis = k;
        end
        for (int s = 0; s < 40; s++) begin
            int d;
            logic [3:0] oh;
            logic [7:0] exp_seg;
            logic [3:0] hx;
            @(negedge clk);
            d = -1;
            if (anode == 4'b1111) d = dis;
            for (int k = 0; k < 4; k++) begin
                oh = 4'b0001 << k;
                if (m_en[k] && anode == ~oh) d = k;
            end
            check("anode_valid", {31'h0, d >= 0}, 32'h1);
            if (d >= 0) begin
                hx = 4'((m_segd >> (4*d)) & 32'hF);
                exp_seg = m_en[d] ? ~{m_dot[d], font[hx]} : 8'hFF;
                check($sformatf("segment_d%0d", d), {24'h0, segment}, {24'h0, exp_seg});
                if (prev_d >= 0 && d != prev_d) begin
                    check("slot_order", d, (prev_d + 1) % 4);
                    if (!first) check("slot_len", run, 3);
                    first = 0;
                    run = 1;
                end else begin
                    run++;
                end
                prev_d = d;
                seen[d] = 1;
            end
        end
        for (int k = 0; k < 4; k++) check($sformatf("slot_seen_%0d", k), {31'h0, seen[k]}, 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] pre, post, r;
        int t0;

        font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        m_reset();
        rst = 1'b0; cs = 0; we = 0; addr = 0; sel = 0; wdata = 0;
        drive_in(0);
        repeat (3) @(negedge clk);
        check("rst_anode", {28'h0, anode}, 32'hF);
        check("rst_segment", {24'h0, segment}, 32'hFF);
        check("rst_led", {24'h0, led}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_ack", {31'h0, ack}, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) br(i);

        // LED byte write, unmapped read
        bus(1'b1, 1, 4'b0001, 32'hA5A5_A5A5, 1'b1, r);
        check("led_byte", {24'h0, led}, 32'hA5);
        br(1);
        br(7);

        // Debounce: short glitch ignored, held level accepted in time
        drive_in(m_in | 32'h100);
        repeat (3) @(negedge clk);
        drive_in(m_in);
        repeat (20) @(negedge clk);
        br(0);
        drive_in(m_in | 32'h100);
        m_pend = m_pend | 32'h100;
        m_in   = m_in | 32'h100;
        repeat (10) @(negedge clk);
        br(0);
        repeat (12) @(negedge clk);

        // Interrupt behaviour
        bw(4, 32'h1);
        bw(6, 32'h0);
        check_outputs();
        set_inputs(m_in | 32'h1);
        check_outputs();
        br(5);
        set_inputs(m_in & ~32'h1);
        br(5);
        check_outputs();
        bw(5, 32'h1);
        check("irq_hold_after_ack", {31'h0, irq}, 32'h1);
        @(negedge clk);
        check("irq_fall", {31'h0, irq}, 32'h0);
        bw(6, 32'h1);
        set_inputs(m_in | 32'h1);
        bw(5, 32'h1);
        set_inputs(m_in & ~32'h1);
        br(5);
        check_outputs();

        // Same-cycle clear and event: sweep the clear across the event
        bw(6, 32'h0);
        bw(4, 32'h0);
        bw(5, 32'hFFFF_FFFF);
        @(negedge clk);
        for (int t = 0; t < 17; t++) begin
            t0 = cyc;
            drive_in(m_in | 32'h1);
            wait_to(t0 + t);
            bus(1'b1, 5, 4'hF, 32'h1, 1'b0, pre);
            wait_to(t0 + 24);
            bus(1'b0, 5, 4'hF, 32'h0, 1'b0, post);
            check($sformatf("w1c_vs_event_t%0d", t), {31'h0, post[0]}, {31'h0, ~pre[0]});
            drive_in(m_in);
            wait_to(t0 + 40);
            bus(1'b1, 5, 4'hF, 32'h1, 1'b0, r);
            m_pend = m_pend & ~32'h1;
            wait_to(t0 + 48);
        end
        br(5);

        // Randomised register/input traffic
        for (int n = 0; n < 80; n++) begin
            int op, idx;
            op  = $urandom_range(0, 4);
            idx = $urandom_range(0, 7);
            case (op)
                0, 1: begin
                    if (idx == 5) bus(1'b1, idx, 4'hF, $urandom, 1'b1, r);
                    else          bus(1'b1, idx, 4'($urandom_range(0, 15)), $urandom, 1'b1, r);
                end
                2, 3: br(idx);
                default: set_inputs(m_in ^ ($urandom & $urandom));
            endcase
            check_outputs();
        end

        // Display scan
        bw(2, 32'h0000_12AF);
        bw(3, 32'h0000_010B);
        repeat (8) @(negedge clk);
        check_display();
        bw(2, $urandom & 32'hFFFF);
        bw(3, (($urandom & 32'hF) << 8) | 32'hB);
        repeat (8) @(negedge clk);
        check_display();

        // Reset in mid-scan with LEDs lit and interrupt pending
        bw(6, 32'h0);
        bw(1, 32'h3C);
        set_inputs(32'h0);
        bw(5, 32'hFFFF_FFFF);
        bw(4, 32'h1);
        set_inputs(32'h1);
        set_inputs(32'h0);
        check_outputs();
        #2 rst = 1'b0;
        #1;
        check("mrst_anode", {28'h0, anode}, 32'hF);
        check("mrst_segment", {24'h0, segment}, 32'hFF);
        check("mrst_led", {24'h0, led}, 32'h0);
        check("mrst_irq", {31'h0, irq}, 32'h0);
        check("mrst_ack", {31'h0, ack}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        m_reset();
        sb.delete();
        @(negedge clk);
        for (int i = 0; i < 8; i++) br(i);
        check_outputs();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_board_io.md
Name: wb_board_io

Overview:
- Parametrised board-IO peripheral on the wishbone peripheral bus: N switches/buttons in, N LEDs out, multiplexed 7-segment display of N digits.
- Adds features the fixed board block lacks:
  - 2-FF synchronisation and debounce of all inputs.
  - Per-bit interrupt mask, edge mode, and a sticky write-1-to-clear pending register.
  - Programmable per-digit enable and dot.
- Single clock domain; the bus runs on clk.

Parameters:
- DEV_ADDR_BITS, 8, address length of the I/O space; registers are word-addressed by wbs_addr_i.
- N_SW, 8, number of switch inputs.
- N_BTN, 5, number of button inputs; N_SW+N_BTN <= 32.
- N_LED, 8, number of LED outputs, <= 32.
- N_DIGIT, 4, number of 7-segment digits, 1..8.
- DEB_CYCLES, 250000, debounce sample period in clk cycles, >= 2.
- SCAN_CYCLES, 50000, clk cycles per displayed digit, >= 2.

Ports:
- clk, input, 1, main clock; also the wishbone clock.
- rst, input, 1, asynchronous, active-low reset.
- switch, input, N_SW, raw switch levels.
- btn, input, N_BTN, raw button levels (1 = pressed).
- led, output, N_LED, LED drive (1 = lit).
- segment, output, 8, active-low segments a..g at [6:0], dot at [7].
- anode, output, N_DIGIT, active-low digit select.
- wbs_cs_i, input, 1, peripheral select.
- wbs_addr_i, input, DEV_ADDR_BITS-2 (bits [DEV_ADDR_BITS-1:2]), word address.
- wbs_sel_i, input, 4, byte enables.
- wbs_data_i, input, 32, write data.
- wbs_we_i, input, 1, write enable.
- wbs_data_o, output, 32, read data.
- wbs_ack_o, output, 1, transfer acknowledge.
- interrupt, output, 1, level interrupt (active-high).

Behaviour:
- Reset (rst low, asynchronous): all outputs and registers are cleared, except that anode and segment reset to all-ones (blank).
  - Cleared: led, wbs_data_o, wbs_ack_o, interrupt, all registers, scan and debounce counters.
  - Synchronisers and debounced state reset to 0.
- Input path. in_raw = {btn, switch} (switch at LSBs), width NI = N_SW+N_BTN.
  - 2-FF synchroniser, then a shared prescaler produces a 1-cycle sample tick every DEB_CYCLES cycles.
  - Per bit: the debounced value updates on a tick only if the current sample equals the sample taken at the previous tick.
  - Worst-case latency from a stable change to the debounced change is 2*DEB_CYCLES+3 cycles.
- Edge detection is on debounced bits, using a 1-cycle delayed copy.
  - rise = ~prev & cur; fall = prev & ~cur.
  - A bit's event = rise, or, if IRQ_EDGE[i] = 1, rise | fall.
- Register map (word index, zero-extended to 32 bits; unlisted indices read 0 and ignore writes):
  - 0 IN (RO): debounced {btn, switch}.
  - 1 LED (RW): [N_LED-1:0].
  - 2 SEG_DATA (RW): 4-bit hex per digit; digit k at [4k+3:4k].
  - 3 SEG_CTRL (RW): enable [N_DIGIT-1:0]; dot [8+N_DIGIT-1:8].
  - 4 IRQ_MASK (RW): [NI-1:0].
  - 5 IRQ_PEND (R/W1C): [NI-1:0].
  - 6 IRQ_EDGE (RW): [NI-1:0].
- RW writes honour wbs_sel_i per byte. Bits above the implemented width read 0.
- Wishbone handshake:
  - When wbs_cs_i=1 and wbs_ack_o=0, the block performs the access and asserts wbs_ack_o for exactly 1 cycle on the next edge, with wbs_data_o valid in the same cycle.
  - A read returns the pre-write value of the addressed register.
  - wbs_ack_o and wbs_data_o return to 0 the following cycle, so back-to-back accesses complete every 2 cycles.
- IRQ_PEND update: each cycle pend <= (pend & ~w1c_mask) | event. A set in the same cycle as a clear wins, so the bit stays 1.
- interrupt is registered: interrupt <= |(IRQ_PEND & IRQ_MASK), giving 1 cycle of latency after pend/mask changes.
  - Masking does not clear pending bits.
- Display:
  - The scan counter advances digit index d every SCAN_CYCLES cycles and wraps from N_DIGIT-1 to 0.
  - anode[d] = 0 only if enable[d]=1; all other anodes are 1.
  - segment = ~{dot[d], hex7seg(SEG_DATA[d])} when enabled, 8'hFF otherwise.
  - Standard hex font, 0-F.
  - Outputs are registered; a register change appears no later than the next digit slot.

Test Plan:
- Reset: hold rst=0 mid-scan, then release → anode=all 1, segment=8'hFF, led=0, interrupt=0; all registers read 0.
- Debounce (DEB_CYCLES=4): glitch btn[0] for 3 cycles → IN unchanged. Hold btn[0] high → IN[N_SW] reads 1 within 11 cycles.
- LED byte write: write LED=32'hA5A5_A5A5 with sel=4'b0001 → led=8'hA5; readback 32'h0000_00A5. A read of index 7 returns 0 with a 1-cycle ack.
- Interrupt:
  - Set IRQ_MASK bit0, IRQ_EDGE=0; switch[0] 0→1 → PEND=1 and interrupt=1 one cycle later.
  - Switch 1→0 → no new event.
  - Write PEND=1 → interrupt falls 1 cycle after the ack.
  - Set EDGE bit0 → falling edges also set PEND.
- Simultaneous: a W1C of PEND bit0 in the same cycle as a bit0 event → PEND bit0 stays 1.
- Display (SCAN_CYCLES=3): SEG_DATA=16'h12AF, enable=4'b1011, dot=4'b0001.
  - Digit0 slot: anode=4'b1110, segment=~{1,hex7seg(F)}.
  - Digit2 slot: anode=4'b1111, segment=8'hFF.
  - The slot sequence wraps after digit3.
